// File: rtl/mips_lsu.sv
// Load/store unit between the MIPS core and the data cache: sub-word loads and
// read-modify-write stores, alignment/op checks, bounded cache wait and abort.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a core request, req_ready=1
// S_READ  | cache line read (load, or first half of a sub-word store)
// S_WRITE | cache line write, always runs to completion
// S_RESP  | one-cycle response pulse to the core
module mips_lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              abort,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              busy,
  output logic              cache_en,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [XLEN-1:0]   cache_wdata,
  input  logic [XLEN-1:0]   cache_rdata,
  input  logic              cache_hit
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic              store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   line_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rdata_q;
  logic [1:0]        err_q;

  function automatic logic [3:0] op_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Request decode, only meaningful while idle
  logic [3:0] req_size;
  logic [2:0] req_size_m1;
  logic       req_illegal;
  logic       req_misal;
  logic       req_full;

  always_comb begin
    req_size    = op_size(req_op[1:0]);
    req_size_m1 = req_size[2:0] - 3'd1;
    req_illegal = (req_op == 3'b111) || (int'(req_size) > BYTES) || (req_store && req_op[2]);
    req_misal   = (req_addr[2:0] & req_size_m1) != 3'b000;
    req_full    = (req_size == 4'(BYTES));
  end

  // Field position: big-endian lanes, so offset 0 is the top byte of the line
  logic [3:0]      cur_size;
  logic [5:0]      shamt;
  logic [XLEN-1:0] field;
  logic [XLEN-1:0] lowmask;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merged;
  logic            sx;

  always_comb begin
    cur_size = op_size(op_q[1:0]);
    shamt    = 6'((BYTES - int'(addr_q[OFF_W-1:0]) - int'(cur_size)) * 8);
    field    = cache_rdata >> shamt;
    sx       = ~op_q[2];
    load_val = '0;
    lowmask  = '1;
    case (op_q[1:0])
      2'b00: begin
        load_val = XLEN'({{56{sx & field[7]}}, field[7:0]});
        lowmask  = XLEN'(64'hFF);
      end
      2'b01: begin
        load_val = XLEN'({{48{sx & field[15]}}, field[15:0]});
        lowmask  = XLEN'(64'hFFFF);
      end
      2'b10: begin
        load_val = XLEN'({{32{sx & field[31]}}, field[31:0]});
        lowmask  = XLEN'(64'hFFFF_FFFF);
      end
      default: begin
        load_val = field;
        lowmask  = '1;
      end
    endcase
    merged = (cache_rdata & ~(lowmask << shamt)) | ((wdata_q & lowmask) << shamt);
  end

  logic timeout;
  assign timeout = (MAX_WAIT != 0) && (cnt_q == WAIT_LIM) && !cache_hit;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= S_IDLE;
      op_q    <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && !abort) begin
            op_q    <= req_op;
            store_q <= req_store;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            if (req_illegal) begin
              state   <= S_RESP;
              err_q   <= ERR_ILLEGAL;
              rdata_q <= '0;
            end else if (req_misal) begin
              state   <= S_RESP;
              err_q   <= ERR_ALIGN;
              rdata_q <= '0;
            end else if (req_store && req_full) begin
              state  <= S_WRITE;
              line_q <= req_wdata;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (cache_hit) begin
            cnt_q <= '0;
            if (store_q) begin
              line_q <= merged;
              state  <= S_WRITE;
            end else begin
              rdata_q <= load_val;
              err_q   <= ERR_OK;
              state   <= S_RESP;
            end
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= ERR_TIMEOUT;
            state   <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (cache_hit) begin
            rdata_q <= '0;
            err_q   <= ERR_OK;
            state   <= S_RESP;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= ERR_TIMEOUT;
            state   <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign resp_valid  = (state == S_RESP);
  assign cache_en    = (state == S_READ) || (state == S_WRITE);
  assign cache_we    = (state == S_WRITE);
  assign cache_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign cache_wdata = line_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: directed table, multi-cycle corner sequences and random
// traffic against a byte-level reference model, at XLEN=32 and XLEN=64.
module tb_mips_lsu;
  localparam int MW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_b;

  logic        req_valid, req_ready, req_store, abort, resp_valid, busy;
  logic        cache_en, cache_we, cache_hit;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, resp_rdata, cache_addr, cache_wdata, cache_rdata;
  logic [1:0]  resp_err;

  logic        req_valid_d, req_ready_d, req_store_d, abort_d, resp_valid_d, busy_d;
  logic        cache_en_d, cache_we_d, cache_hit_d;
  logic [2:0]  req_op_d;
  logic [31:0] req_addr_d, cache_addr_d;
  logic [63:0] req_wdata_d, resp_rdata_d, cache_wdata_d, cache_rdata_d;
  logic [1:0]  resp_err_d;

  mips_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .abort(abort), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .cache_en(cache_en), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit));

  mips_lsu #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(255)) dut64 (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_d), .req_ready(req_ready_d),
    .req_store(req_store_d), .req_op(req_op_d), .req_addr(req_addr_d), .req_wdata(req_wdata_d),
    .abort(abort_d), .resp_valid(resp_valid_d), .resp_rdata(resp_rdata_d), .resp_err(resp_err_d),
    .busy(busy_d), .cache_en(cache_en_d), .cache_we(cache_we_d), .cache_addr(cache_addr_d),
    .cache_wdata(cache_wdata_d), .cache_rdata(cache_rdata_d), .cache_hit(cache_hit_d));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte-by-byte, big-endian lanes within a line of nb bytes
  function automatic int sz_of(input logic [2:0] op);
    case (op[1:0])
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] ld_model(input logic [63:0] line, input int nb, input int k,
                                           input int s, input bit sgn);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < s; i++) v = (v << 8) | ((line >> (8 * (nb - 1 - k - i))) & 64'hFF);
    if (sgn && s < 8 && v[8*s-1]) v = v | (~64'd0 << (8 * s));
    if (nb == 4) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] st_model(input logic [63:0] line, input int nb, input int k,
                                           input int s, input logic [63:0] wd);
    logic [63:0] v, b;
    int pos;
    v = line;
    for (int i = 0; i < s; i++) begin
      pos = 8 * (nb - 1 - k - i);
      b   = (wd >> (8 * (s - 1 - i))) & 64'hFF;
      v   = (v & ~(64'hFF << pos)) | (b << pos);
    end
    return v;
  endfunction

  logic [31:0] mem32 [16];

  // One transaction on the 32-bit LSU; the task plays the cache with chosen hit delays
  task automatic txn32(input logic st, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input int dr, input int dw, input int ab_r,
                       input int ab_w, output int lat, output logic got,
                       output logic [31:0] rd, output logic [1:0] er, output logic wrote,
                       output logic [31:0] wline, output int en_cyc, output logic addr_bad,
                       output logic rdy_ab);
    int rc, wc;
    logic ab_prev;
    rc = 0; wc = 0; got = 0; wrote = 0; wline = 0; en_cyc = 0; addr_bad = 0;
    lat = 0; rd = 0; er = 0; rdy_ab = 0; ab_prev = 0;
    @(negedge clk);
    req_valid = 1; req_store = st; req_op = op; req_addr = addr; req_wdata = wd;
    abort = 0; cache_hit = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      req_valid = 0;
      if (ab_prev) rdy_ab = req_ready;
      ab_prev = abort;
      abort = 0;
      cache_hit = 0;
      if (resp_valid) begin
        got = 1; lat = n; rd = resp_rdata; er = resp_err;
      end else if (cache_en) begin
        en_cyc++;
        if (cache_addr !== {addr[31:2], 2'b00}) addr_bad = 1;
        if (!cache_we) begin
          cache_rdata = mem32[addr[5:2]];
          if (rc == ab_r) abort = 1;
          if (rc == dr) cache_hit = 1;
          rc++;
        end else begin
          if (wc == ab_w) abort = 1;
          if (wc == dw) begin
            cache_hit = 1; wrote = 1; wline = cache_wdata;
            mem32[addr[5:2]] = cache_wdata;
          end
          wc++;
        end
      end
    end
  endtask

  task automatic txn64(input logic [2:0] op, input logic [31:0] addr, input logic [63:0] line,
                       output int lt, output logic [63:0] rdv, output logic [1:0] erv);
    lt = 0; rdv = 0; erv = 0;
    @(negedge clk);
    req_valid_d = 1; req_op_d = op; req_addr_d = addr;
    for (int n = 1; n <= 10 && lt == 0; n++) begin
      @(negedge clk);
      req_valid_d = 0;
      cache_hit_d = 0;
      if (resp_valid_d) begin
        lt = n; rdv = resp_rdata_d; erv = resp_err_d;
      end else if (cache_en_d) begin
        cache_rdata_d = line; cache_hit_d = 1;
      end
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] line;
    logic [31:0] exp_rd;
    logic [1:0]  exp_er;
    int          exp_lat;
    logic        exp_wr;
    logic [31:0] exp_wl;
  } vec_t;

  vec_t        vt [12];
  int          lat, en, e_lat, s, k, dr, dw;
  logic        got, wr, abad, rab, st, ill, mis, e_wr, seen;
  logic [31:0] rd, wl, addr, wd, line, e_rd, e_wl;
  logic [1:0]  er, e_er;
  logic [2:0]  op;
  logic [63:0] rd64, line64, e_rd64;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 3'b000, 32'h100, 32'h0,  32'h80FF7F01, 32'hFFFFFF80, 2'd0, 2, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 3'b100, 32'h100, 32'h0,  32'h80FF7F01, 32'h00000080, 2'd0, 2, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 3'b001, 32'h102, 32'h0,  32'h80FF7F01, 32'h00007F01, 2'd0, 2, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 3'b010, 32'h100, 32'h0,  32'h80FF7F01, 32'h80FF7F01, 2'd0, 2, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 3'b000, 32'h101, 32'h5A, 32'h11223344, 32'h0,        2'd0, 3, 1'b1, 32'h115A3344};
    vt[5]  = '{1'b0, 3'b001, 32'h101, 32'h0,  32'h11223344, 32'h0,        2'd1, 1, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 3'b010, 32'h102, 32'h0,  32'h11223344, 32'h0,        2'd1, 1, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 3'b011, 32'h100, 32'h0,  32'h11223344, 32'h0,        2'd3, 1, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 3'b100, 32'h100, 32'h7,  32'h11223344, 32'h0,        2'd3, 1, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 3'b010, 32'h108, 32'hDEADBEEF, 32'h0,  32'h0,        2'd0, 2, 1'b1, 32'hDEADBEEF};
    vt[10] = '{1'b0, 3'b101, 32'h100, 32'h0,  32'h80FF7F01, 32'h000080FF, 2'd0, 2, 1'b0, 32'h0};
    vt[11] = '{1'b0, 3'b111, 32'h100, 32'h0,  32'h80FF7F01, 32'h0,        2'd3, 1, 1'b0, 32'h0};

    rst_b = 0;
    req_valid = 0; req_store = 0; req_op = 0; req_addr = 0; req_wdata = 0; abort = 0;
    cache_hit = 0; cache_rdata = 0;
    req_valid_d = 0; req_store_d = 0; req_op_d = 0; req_addr_d = 0; req_wdata_d = 0;
    abort_d = 0; cache_hit_d = 0; cache_rdata_d = 0;
    for (int i = 0; i < 16; i++) mem32[i] = $urandom;
    #23;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset cache_en", 64'({cache_en, cache_we}), 64'd0);
    chk("reset resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
    chk("reset cache_addr", 64'(cache_addr), 64'd0);
    chk("reset cache_wdata", 64'(cache_wdata), 64'd0);
    @(negedge clk);
    rst_b = 1;

    // Directed table, zero-wait cache
    for (int i = 0; i < 12; i++) begin
      mem32[vt[i].addr[5:2]] = vt[i].line;
      txn32(vt[i].st, vt[i].op, vt[i].addr, vt[i].wd, 0, 0, -1, -1,
            lat, got, rd, er, wr, wl, en, abad, rab);
      chk($sformatf("vec%0d err", i), 64'(er), 64'(vt[i].exp_er));
      chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(vt[i].exp_rd));
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vt[i].exp_lat));
      chk($sformatf("vec%0d cache_en cycles", i), 64'(en), 64'(vt[i].exp_lat - 1));
      chk($sformatf("vec%0d wrote", i), 64'(wr), 64'(vt[i].exp_wr));
      if (vt[i].exp_wr) chk($sformatf("vec%0d write line", i), 64'(wl), 64'(vt[i].exp_wl));
      chk($sformatf("vec%0d cache_addr", i), 64'(abad), 64'd0);
    end

    // Timeout: no hit at all, then a hit on the last allowed cycle
    mem32[0] = 32'h80FF7F01;
    txn32(1'b0, 3'b010, 32'h100, 32'h0, 10, 0, -1, -1, lat, got, rd, er, wr, wl, en, abad, rab);
    chk("timeout err", 64'(er), 64'd2);
    chk("timeout cache_en cycles", 64'(en), 64'(MW + 1));
    chk("timeout latency", 64'(lat), 64'(MW + 2));
    txn32(1'b0, 3'b010, 32'h100, 32'h0, MW, 0, -1, -1, lat, got, rd, er, wr, wl, en, abad, rab);
    chk("late hit err", 64'(er), 64'd0);
    chk("late hit rdata", 64'(rd), 64'h80FF7F01);
    chk("late hit cache_en cycles", 64'(en), 64'(MW + 1));

    // Abort in the 2nd READ cycle, abort racing a hit, abort ignored during WRITE
    txn32(1'b0, 3'b010, 32'h100, 32'h0, 10, 0, 1, -1, lat, got, rd, er, wr, wl, en, abad, rab);
    chk("abort read no resp", 64'(got), 64'd0);
    chk("abort read ready after", 64'(rab), 64'd1);
    chk("abort read cache_en cycles", 64'(en), 64'd2);
    txn32(1'b0, 3'b010, 32'h100, 32'h0, 1, 0, 1, -1, lat, got, rd, er, wr, wl, en, abad, rab);
    chk("abort vs hit no resp", 64'(got), 64'd0);
    mem32[4] = 32'h11223344;
    txn32(1'b1, 3'b000, 32'h111, 32'hA5, 0, 1, -1, 0, lat, got, rd, er, wr, wl, en, abad, rab);
    chk("abort write resp", 64'(got), 64'd1);
    chk("abort write err", 64'(er), 64'd0);
    chk("abort write latency", 64'(lat), 64'd4);
    chk("abort write line", 64'(wl), 64'h11A53344);

    // Reset pulse while a full-width store sits in WRITE
    @(negedge clk);
    req_valid = 1; req_store = 1; req_op = 3'b010; req_addr = 32'h104; req_wdata = 32'hCAFEF00D;
    cache_hit = 0;
    @(negedge clk);
    req_valid = 0;
    chk("pre-reset in write", 64'({cache_en, cache_we}), 64'd3);
    #1 rst_b = 0;
    #1;
    chk("async reset cache strobes", 64'({cache_en, cache_we, busy, resp_valid}), 64'd0);
    chk("async reset ready", 64'(req_ready), 64'd1);
    chk("async reset addr/data", 64'({cache_addr, cache_wdata}), 64'd0);
    @(negedge clk);
    rst_b = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("no resp after reset", 64'(seen), 64'd0);

    // Random traffic, 32-bit
    for (int t = 0; t < 200; t++) begin
      st = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      if (!st && op == 3'b110) op = 3'b010;
      s = sz_of(op);
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(s - 1);
      wd = $urandom;
      dr = $urandom_range(0, 4);
      dw = $urandom_range(0, 4);
      line = mem32[addr[5:2]];
      k = int'(addr[1:0]);
      ill = (op == 3'b111) || (s > 4) || (st && op[2]);
      mis = (addr % s) != 0;
      e_rd = 0; e_wr = 0; e_wl = 0; e_er = 0;
      if (ill) begin
        e_er = 3; e_lat = 1;
      end else if (mis) begin
        e_er = 1; e_lat = 1;
      end else if (!st) begin
        if (dr > MW) begin e_er = 2; e_lat = MW + 2; end
        else begin e_rd = 32'(ld_model(64'(line), 4, k, s, !op[2])); e_lat = dr + 2; end
      end else if (s == 4) begin
        if (dw > MW) begin e_er = 2; e_lat = MW + 2; end
        else begin e_lat = dw + 2; e_wr = 1; e_wl = wd; end
      end else begin
        if (dr > MW) begin e_er = 2; e_lat = MW + 2; end
        else if (dw > MW) begin e_er = 2; e_lat = dr + MW + 3; end
        else begin e_lat = dr + dw + 3; e_wr = 1; e_wl = 32'(st_model(64'(line), 4, k, s, 64'(wd))); end
      end
      txn32(st, op, addr, wd, dr, dw, -1, -1, lat, got, rd, er, wr, wl, en, abad, rab);
      chk($sformatf("rnd%0d err", t), 64'(er), 64'(e_er));
      chk($sformatf("rnd%0d rdata", t), 64'(rd), 64'(e_rd));
      chk($sformatf("rnd%0d latency", t), 64'(lat), 64'(e_lat));
      chk($sformatf("rnd%0d wrote", t), 64'(wr), 64'(e_wr));
      if (e_wr) chk($sformatf("rnd%0d write line", t), 64'(wl), 64'(e_wl));
      chk($sformatf("rnd%0d cache_addr", t), 64'(abad), 64'd0);
    end

    // 64-bit instance: doubleword and word-unsigned loads
    txn64(3'b011, 32'h8, 64'h8899AABBCCDDEEFF, lat, rd64, er);
    chk("x64 LD value", rd64, 64'h8899AABBCCDDEEFF);
    chk("x64 LD latency", 64'(lat), 64'd2);
    txn64(3'b110, 32'hC, 64'h0123456789ABCDEF, lat, rd64, er);
    chk("x64 LWU value", rd64, 64'h0000000089ABCDEF);
    txn64(3'b010, 32'hC, 64'h0123456789ABCDEF, lat, rd64, er);
    chk("x64 LW value", rd64, 64'hFFFFFFFF89ABCDEF);
    txn64(3'b011, 32'h4, 64'h0123456789ABCDEF, lat, rd64, er);
    chk("x64 LD misaligned", 64'({er, 6'(lat)}), 64'({2'd1, 6'd1}));
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      s = sz_of(op);
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(s - 1);
      line64 = {$urandom, $urandom};
      e_rd64 = 0; e_er = 0; e_lat = 2;
      if (op == 3'b111) begin e_er = 3; e_lat = 1; end
      else if ((addr % s) != 0) begin e_er = 1; e_lat = 1; end
      else e_rd64 = ld_model(line64, 8, int'(addr[2:0]), s, !op[2]);
      txn64(op, addr, line64, lat, rd64, er);
      chk($sformatf("x64 rnd%0d err", t), 64'(er), 64'(e_er));
      chk($sformatf("x64 rnd%0d rdata", t), rd64, e_rd64);
      chk($sformatf("x64 rnd%0d latency", t), 64'(lat), 64'(e_lat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
